bmult_mac_acc: RTL and testbench
================================

Name: bmult_mac_acc

Overview:
- Downstream accumulation stage for the 10x10 bitheap multiplier.
- Accepts operand pairs over a valid/ready stream, drives them into an external Bmult10x10 instance (mul_a/mul_b -> P), and tracks the multiplier's fixed latency with a tagged valid pipeline.
- Sums returning products into a wide accumulator.
- When the product tagged "last" arrives, presents the dot-product result on a valid/ready output port.

Parameters:
- W, 10, operand width; must match the multiplier (product width 2*W).
- MUL_LAT, 2, clock cycles from the mul_a/mul_b change to the matching mul_p being stable and sampled.
- ACC_W, 32, accumulator width; must be >= 2*W.
- CNT_W, 16, product-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_last  in  1  marks the final pair of a sequence.
- mul_a  out  W  registered operand to multiplier A.
- mul_b  out  W  registered operand to multiplier B.
- mul_p  in  2*W  multiplier product P.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W  accumulated sum (modulo 2^ACC_W).
- out_count  out  CNT_W  number of products in the sum (saturating).
- out_ovf  out  1  sticky: carry out of ACC_W occurred during this sequence.

Behaviour:
- Reset (async, rst_n=0): state=ACCUM, all of the following are 0: acc, count, ovf, valid pipeline, mul_a, mul_b, out_valid, out_acc, out_count, out_ovf.
- Accept: a pair is accepted when in_valid & in_ready at a rising edge.
- Issue: at the accepting edge, mul_a<=in_a and mul_b<=in_b. vld[0]<=1 and tag[0]<=in_last; otherwise vld[0]<=0. mul_a/mul_b hold their value when nothing is accepted.
- Latency tracking: vld/tag shift register of depth MUL_LAT. An entry issued at edge t reaches stage MUL_LAT-1 so that mul_p is sampled at edge t+MUL_LAT.
- Accumulate: at any edge where vld[MUL_LAT-1]=1:
  - acc<=acc+zero-extended mul_p;
  - ovf|=carry out of bit ACC_W-1;
  - count<=count+1, saturating at 2^CNT_W-1.
- ACCUM state:
  - in_ready=1.
  - On accepting a pair with in_last=1, go to DRAIN.
- DRAIN state:
  - in_ready=0.
  - Wait for the tagged entry to reach the sample stage.
  - At that edge, load out_acc=acc+mul_p, out_count=count+1, out_ovf including the final carry; set out_valid=1.
  - Clear acc, count and ovf to 0; go to HOLD.
- HOLD state:
  - in_ready=0.
  - out_valid, out_acc, out_count and out_ovf stay stable until out_valid & out_ready.
  - On that handshake edge, clear out_valid and go to ACCUM.
  - in_ready rises in the cycle after the handshake; there is no bypass.
- Single-pair sequence (in_last on the first pair) is legal; out_count=1.
- in_last on a pair accepted while earlier products are still in flight: all earlier products are summed before the tagged one, because the pipeline is in order.
- Result latency: the last pair is accepted at edge t; out_valid is asserted from edge t+MUL_LAT.
- in_valid while in_ready=0 is ignored. Upstream must hold its data, per standard valid/ready rules.
- Reset mid-operation (any state): all in-flight products and partial sums are discarded; no result is emitted.
- Invariants (bench asserts):
  - in_ready and out_valid are never both 1.
  - out_* never change while out_valid=1 and out_ready=0.
- The environment connects mul_a/mul_b/mul_p to Bmult10x10 with MUL_LAT matched to its register depth.

Test Plan:
- Reset, single pair A=1023, B=1023, in_last=1 -> out_valid exactly MUL_LAT=2 edges after acceptance; out_acc=1046529, out_count=1, out_ovf=0.
- Back-to-back pairs (3,5), (7,11), (13,17), (19,23, last) with in_valid held high -> in_ready stays 1 through acceptance of the 4th pair. Result: out_acc=15+77+221+437=750, out_count=4.
- Same sequence, then out_ready held 0 for 5 cycles -> out_valid=1, out_acc=750 stable and in_ready=0 throughout. Handshake occurs; the next cycle in_ready=1; a new sequence (2,2, last) gives out_acc=4, confirming the accumulator was cleared.
- ACC_W=20, pairs (1023,1023), (1023,1023, last) -> out_acc=1044482 (2093058 mod 2^20), out_ovf=1. The following sequence (1,1, last) gives out_ovf=0, out_acc=1.
- Assert rst_n=0 while in DRAIN with 2 products in flight -> all outputs go to 0 immediately (async). After release, in_ready=1, no spurious out_valid, and a fresh (4,5, last) sequence gives out_acc=20.
- Random operands with random in_valid/out_ready over 1000 sequences -> every result matches a reference model sum; invariants hold throughout.

Source files
------------

// File: rtl/bmult_mac_acc.sv
// bmult_mac_acc: dot-product accumulator placed after an external 10x10 multiplier.
// Operand pairs arrive on a valid/ready stream and are sent to the multiplier.
// Each returning product is added to a wide accumulator. When the product tagged
// "last" arrives, the sum and the product count are held on a valid/ready result port.
module bmult_mac_acc #(
  parameter int unsigned W       = 10,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic               in_last,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [2*W-1:0]     mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_ovf
);

  // One extra bit on the adder catches the carry out of the accumulator.
  localparam int unsigned SW = ACC_W + 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state;
  logic [MUL_LAT-1:0] vld;
  logic [MUL_LAT-1:0] tag;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic               ovf;

  logic               accept;
  logic               sample;
  logic               final_hit;
  logic [SW-1:0]      sum;
  logic [CNT_W-1:0]   count_inc;

  // Handshake decode, the product adder and the saturating count increment.
  always_comb begin
    accept    = in_valid & in_ready;
    sample    = vld[MUL_LAT-1];
    final_hit = sample & tag[MUL_LAT-1] & (state == DRAIN);
    sum       = {1'b0, acc} + SW'(mul_p);
    count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
  end

  // Sequencer, operand issue, latency pipeline, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      vld       <= '0;
      tag       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      // The tagged valid pipeline keeps the multiplier's fixed latency.
      vld[0] <= accept;
      tag[0] <= accept & in_last;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end

      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end

      if (final_hit) begin
        // The last product goes straight to the result, and the sums restart at zero.
        out_acc   <= sum[ACC_W-1:0];
        out_count <= count_inc;
        out_ovf   <= ovf | sum[ACC_W];
        out_valid <= 1'b1;
        acc       <= '0;
        count     <= '0;
        ovf       <= 1'b0;
      end else if (sample) begin
        acc   <= sum[ACC_W-1:0];
        count <= count_inc;
        ovf   <= ovf | sum[ACC_W];
      end

      case (state)
        ACCUM: begin
          if (accept && in_last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (final_hit) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmult_mac_acc.sv
// Scoreboard bench for bmult_mac_acc. Two instances share one stimulus stream:
// a default instance and a narrow one (ACC_W=20, CNT_W=3) that reaches
// accumulator overflow and count saturation. Each instance has its own model
// of the multiplier.
`timescale 1ns/1ps
module tb_bmult_mac_acc;
  localparam int unsigned W       = 10;
  localparam int unsigned PW      = 2 * W;
  localparam int unsigned MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid, out_ovf;
  logic [W-1:0]  mul_a, mul_b;
  logic [PW-1:0] mul_p;
  logic [31:0]   out_acc;
  logic [15:0]   out_count;

  logic          in_ready2, out_valid2, out_ovf2;
  logic [W-1:0]  mul_a2, mul_b2;
  logic [PW-1:0] mul_p2;
  logic [19:0]   out_acc2;
  logic [2:0]    out_count2;

  bmult_mac_acc u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf));

  bmult_mac_acc #(.W(W), .MUL_LAT(MUL_LAT), .ACC_W(20), .CNT_W(3)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(mul_a2), .mul_b(mul_b2),
    .mul_p(mul_p2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_acc(out_acc2), .out_count(out_count2), .out_ovf(out_ovf2));

  // Multiplier model: the product is registered MUL_LAT-1 times after mul_a/mul_b.
  logic [PW-1:0] pipe1 [MUL_LAT-1];
  logic [PW-1:0] pipe2 [MUL_LAT-1];
  always @(posedge clk) begin
    pipe1[0] <= PW'(mul_a) * PW'(mul_b);
    pipe2[0] <= PW'(mul_a2) * PW'(mul_b2);
    for (int i = 1; i < int'(MUL_LAT) - 1; i++) begin
      pipe1[i] <= pipe1[i-1];
      pipe2[i] <= pipe2[i-1];
    end
  end
  assign mul_p  = pipe1[MUL_LAT-2];
  assign mul_p2 = pipe2[MUL_LAT-2];

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint unsigned sum;
    longint unsigned n;
    longint unsigned acc_cyc;
  } exp_t;
  exp_t sb[$];

  longint unsigned last_acc_cyc = 0;
  int stalls = 0;
  int hold_cnt = 0;
  bit rnd_rdy = 1'b0;
  bit seen = 1'b0;
  bit hs_pend = 1'b0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Hold one pair valid until it is accepted. Return just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    int budget;
    budget = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!in_ready) begin
      stalls++;
      budget++;
      if (budget > 300) begin
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", budget);
        finish_sim();
      end
      @(negedge clk);
    end
    last_acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push_exp(input longint unsigned sum, input longint unsigned n);
    exp_t e;
    e.sum = sum; e.n = n; e.acc_cyc = last_acc_cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle;
    int budget;
    budget = 0;
    while (sb.size() != 0 || hs_pend || out_valid) begin
      budget++;
      if (budget > 300) begin
        errors++;
        $display("FAIL idle_timeout: %0d results still pending", sb.size());
        finish_sim();
      end
      @(negedge clk);
    end
  endtask

  logic        pv, pr;
  logic [31:0] p_acc;
  logic [15:0] p_cnt;
  logic        p_ovf;
  logic [19:0] p_acc2;
  logic [2:0]  p_cnt2;
  logic        p_ovf2;

  // Monitor: checks the invariants, compares results with the scoreboard and drives out_ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0; hs_pend = 1'b0; pv = 1'b0; pr = 1'b0;
    end else begin
      check("rdy_vld_excl", 64'(in_ready & out_valid), 64'd0);
      check("rdy_vld_excl20", 64'(in_ready2 & out_valid2), 64'd0);
      if (pv && !pr) begin
        check("hold_stable", 64'((out_acc != p_acc) || (out_count != p_cnt) || (out_ovf != p_ovf) ||
                               (out_acc2 != p_acc2) || (out_count2 != p_cnt2) || (out_ovf2 != p_ovf2) ||
                               !out_valid), 64'd0);
      end
      if (hs_pend) begin
        hs_pend = 1'b0;
        check("ready_after_hs", 64'(in_ready), 64'd1);
        check("valid_after_hs", 64'(out_valid), 64'd0);
      end else if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL spurious_result: out_valid=1 out_acc=%0d with no result expected", out_acc);
        end else begin
          exp_t e;
          e = sb[0];
          check("latency", cyc - e.acc_cyc, 64'(MUL_LAT));
          check("acc", 64'(out_acc), e.sum & 64'hFFFF_FFFF);
          check("count", 64'(out_count), (e.n > 65535) ? 64'd65535 : e.n);
          check("ovf", 64'(out_ovf), 64'(e.sum >= 64'h1_0000_0000));
          check("valid20", 64'(out_valid2), 64'd1);
          check("acc20", 64'(out_acc2), e.sum & 64'hF_FFFF);
          check("count3", 64'(out_count2), (e.n > 7) ? 64'd7 : e.n);
          check("ovf20", 64'(out_ovf2), 64'(e.sum >= 64'h10_0000));
        end
      end
      pv = out_valid;
      p_acc = out_acc; p_cnt = out_count; p_ovf = out_ovf;
      p_acc2 = out_acc2; p_cnt2 = out_count2; p_ovf2 = out_ovf2;
      if (out_valid) begin
        if (hold_cnt > 0) begin
          out_ready = 1'b0;
          hold_cnt--;
        end else begin
          out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end else begin
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      pr = out_ready;
      if (out_valid && out_ready) begin
        hs_pend = 1'b1;
        seen = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  initial begin
    longint unsigned sum;
    int len;
    logic [W-1:0] a, b;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_acc", 64'(out_acc), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // A single pair with the largest operands
    send(10'd1023, 10'd1023, 1'b1);
    push_exp(64'd1046529, 64'd1);
    wait_idle();

    // Four back-to-back pairs
    stalls = 0;
    send(10'd3, 10'd5, 1'b0);
    send(10'd7, 10'd11, 1'b0);
    send(10'd13, 10'd17, 1'b0);
    send(10'd19, 10'd23, 1'b1);
    push_exp(64'd750, 64'd4);
    check("b2b_stalls", 64'(stalls), 64'd0);
    wait_idle();

    // Same sequence with the result held back for 5 cycles, then a 1-pair sequence
    hold_cnt = 5;
    send(10'd3, 10'd5, 1'b0);
    send(10'd7, 10'd11, 1'b0);
    send(10'd13, 10'd17, 1'b0);
    send(10'd19, 10'd23, 1'b1);
    push_exp(64'd750, 64'd4);
    wait_idle();
    send(10'd2, 10'd2, 1'b1);
    push_exp(64'd4, 64'd1);
    wait_idle();

    // Overflow of the 20-bit accumulator, then a clean sequence
    send(10'd1023, 10'd1023, 1'b0);
    send(10'd1023, 10'd1023, 1'b1);
    push_exp(64'd2093058, 64'd2);
    wait_idle();
    send(10'd1, 10'd1, 1'b1);
    push_exp(64'd1, 64'd1);
    wait_idle();

    // Reset in DRAIN with two products in flight
    send(10'd6, 10'd7, 1'b0);
    send(10'd8, 10'd9, 1'b1);
    check("drain_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_acc", 64'(out_acc), 64'd0);
    check("arst_out_count", 64'(out_count), 64'd0);
    check("arst_mul_a", 64'(mul_a), 64'd0);
    check("arst_mul_b", 64'(mul_b), 64'd0);
    check("arst_out_acc20", 64'(out_acc2), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_release_ready", 64'(in_ready), 64'd1);
    check("rst_release_valid", 64'(out_valid), 64'd0);
    send(10'd4, 10'd5, 1'b1);
    push_exp(64'd20, 64'd1);
    wait_idle();

    // Random sequences with random in_valid gaps and random out_ready
    rnd_rdy = 1'b1;
    for (int s = 0; s < 1000; s++) begin
      len = int'($urandom_range(1, 10));
      sum = 0;
      for (int k = 0; k < len; k++) begin
        a = ($urandom_range(0, 7) == 0) ? 10'd1023 : W'($urandom_range(0, 1023));
        b = ($urandom_range(0, 7) == 0) ? 10'd1023 : W'($urandom_range(0, 1023));
        sum += longint'(a) * longint'(b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(a, b, (k == len - 1) ? 1'b1 : 1'b0);
      end
      push_exp(sum, longint'(len));
    end
    wait_idle();
    rnd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    finish_sim();
  end

endmodule
